// File: rtl/vpg_pkg.sv
// Shared definitions for the video pattern generator mode controller.
// Holds the mode-code constants, the default supported-mode mask, the
// controller state encoding and a small mask lookup helper.
package vpg_pkg;

    localparam logic [3:0] VGA_640x480p60   = 4'd0;
    localparam logic [3:0] MODE_720x480     = 4'd1;
    localparam logic [3:0] MODE_1024x768    = 4'd2;
    localparam logic [3:0] MODE_1280x1024   = 4'd3;
    localparam logic [3:0] FHD_1920x1080p60 = 4'd4;
    localparam logic [3:0] VESA_1600x1200p60 = 4'd5;

    localparam logic [15:0] MODE_MASK_DEFAULT = 16'h003F;

    // Width of the shared timing counter; timing parameters must fit in it.
    localparam int CNT_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_MIN_WAIT  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_SETTLE    = 3'd4
    } vpg_state_e;

    function automatic logic mode_supported(input logic [15:0] mask,
                                            input logic [3:0]  code);
        return mask[code];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   en            - arbitration enabled this cycle (grants forced low otherwise)
//   req_a, req_b  - requests
//   gnt_a, gnt_b  - combinational one-hot grants
// The priority pointer only moves when both sides contend, and then it moves
// to the side that lost, so a lone requester never steals the other's turn.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic ptr_b;    // 0: A has priority, 1: B has priority

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = !ptr_b;
                gnt_b = ptr_b;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_b <= 1'b0;
        end else if (en && req_a && req_b) begin
            ptr_b <= !ptr_b;
        end
    end

endmodule

// File: rtl/vpg_mode_ctrl.sv
// Display-mode change sequencer for the video pattern generator.
// Arbitrates requests from A (keys/switches) and B (host CPU), checks them
// against MODE_MASK, pulses mode_change to the generator and waits for the
// regenerated pixel clock to lock and stay locked before going idle again.
// Ports:
//   clk_100, reset              - system clock, synchronous active-high reset
//   a_valid/a_mode/a_ready      - requester A handshake
//   b_valid/b_mode/b_ready      - requester B handshake
//   pll_locked                  - generator lock, asynchronous to clk_100
//   mode, mode_change           - mode code and one-cycle strobe to generator
//   busy, done, err_unsup       - status: change in flight, success, rejected
//   fault                       - sticky lock failure after retry
//   cur_mode                    - last successfully applied mode
module vpg_mode_ctrl
    import vpg_pkg::*;
#(
    parameter logic [15:0] MODE_MASK     = MODE_MASK_DEFAULT,
    parameter logic [3:0]  DEFAULT_MODE  = VGA_640x480p60,
    parameter int          MIN_WAIT      = 32,
    parameter int          SETTLE_CYCLES = 1024,
    parameter int          LOCK_TIMEOUT  = 1_000_000
) (
    input  logic       clk_100,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [3:0] a_mode,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [3:0] b_mode,
    output logic       b_ready,
    input  logic       pll_locked,
    output logic [3:0] mode,
    output logic       mode_change,
    output logic       busy,
    output logic       done,
    output logic       err_unsup,
    output logic       fault,
    output logic [3:0] cur_mode
);

    localparam logic [CNT_W-1:0] MIN_WAIT_LAST = CNT_W'(MIN_WAIT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    vpg_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             retry, retry_nxt;
    logic             restore, restore_nxt;
    logic [3:0]       mode_nxt, cur_mode_nxt, req_mode;
    logic             fault_nxt, done_nxt, err_nxt, mc_nxt;
    logic             lock_p0, lock_p1;
    logic             arb_en, gnt_a, gnt_b;

    // Stage p0/p1: two-flop synchronizer for the asynchronous lock input.
    always_ff @(posedge clk_100) begin
        lock_p0 <= pll_locked;
        lock_p1 <= lock_p0;
    end

    assign arb_en  = (state == ST_IDLE);
    assign a_ready = gnt_a;
    assign b_ready = gnt_b;
    assign busy    = (state != ST_IDLE);

    rr_arb2 u_arb (
        .clk   (clk_100),
        .reset (reset),
        .en    (arb_en),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        retry_nxt    = retry;
        restore_nxt  = restore;
        mode_nxt     = mode;
        cur_mode_nxt = cur_mode;
        fault_nxt    = fault;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        mc_nxt       = 1'b0;
        req_mode     = gnt_a ? a_mode : b_mode;

        unique case (state)
            ST_IDLE: begin
                if (gnt_a || gnt_b) begin
                    if (!mode_supported(MODE_MASK, req_mode)) begin
                        err_nxt = 1'b1;
                    end else if (req_mode == cur_mode) begin
                        done_nxt  = 1'b1;
                        fault_nxt = 1'b0;
                    end else begin
                        mode_nxt    = req_mode;
                        retry_nxt   = 1'b0;
                        restore_nxt = 1'b0;
                        state_nxt   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mc_nxt    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_MIN_WAIT;
            end
            ST_MIN_WAIT: begin
                if (cnt == MIN_WAIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_WAIT_LOCK;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                // The counter may arrive here already advanced from a settle
                // attempt that lost lock, hence the >= comparison.
                if (lock_p1) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_SETTLE;
                end else if (cnt >= TIMEOUT_LAST) begin
                    if (restore) begin
                        // Restoring the old mode failed too: give up, mode
                        // already holds cur_mode.
                        state_nxt = ST_IDLE;
                    end else if (!retry) begin
                        retry_nxt = 1'b1;
                        state_nxt = ST_ISSUE;
                    end else begin
                        fault_nxt   = 1'b1;
                        mode_nxt    = cur_mode;
                        retry_nxt   = 1'b1;
                        restore_nxt = 1'b1;
                        state_nxt   = ST_ISSUE;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_SETTLE: begin
                if (!lock_p1) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = ST_IDLE;
                    // A successful restore only returns the generator to the
                    // old mode; the request itself failed, so no done and the
                    // fault flag stays set.
                    if (!restore) begin
                        cur_mode_nxt = mode;
                        done_nxt     = 1'b1;
                        fault_nxt    = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state       <= ST_ISSUE;
            cnt         <= '0;
            retry       <= 1'b0;
            restore     <= 1'b0;
            mode        <= DEFAULT_MODE;
            cur_mode    <= DEFAULT_MODE;
            fault       <= 1'b0;
            done        <= 1'b0;
            err_unsup   <= 1'b0;
            mode_change <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry       <= retry_nxt;
            restore     <= restore_nxt;
            mode        <= mode_nxt;
            cur_mode    <= cur_mode_nxt;
            fault       <= fault_nxt;
            done        <= done_nxt;
            err_unsup   <= err_nxt;
            mode_change <= mc_nxt;
        end
    end

endmodule
